// File: rtl/lpc_host_if.sv
// Request/response and LPC pin bundle for lpc_host.
// master is the host's view; slave is the requester plus the LPC target.
interface lpc_host_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        resp_valid;
   logic [7:0]  resp_rdata;
   logic        resp_error;
   logic        resp_timeout;
   logic        LPC_FRAME;
   logic [3:0]  LPC_LAD_OUT;
   logic        LPC_LAD_OE;
   logic [3:0]  LPC_LAD_IN;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, LPC_LAD_IN,
      output req_ready, resp_valid, resp_rdata, resp_error, resp_timeout,
             LPC_FRAME, LPC_LAD_OUT, LPC_LAD_OE
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, LPC_LAD_IN,
      input  req_ready, resp_valid, resp_rdata, resp_error, resp_timeout,
             LPC_FRAME, LPC_LAD_OUT, LPC_LAD_OE
   );
endinterface

// File: rtl/lpc_host.sv
// LPC initiator for single-byte I/O read/write cycles with wait, error-SYNC
// and no-response abort handling. All pin outputs are registered.
module lpc_host #(
   parameter int SYNC_TIMEOUT = 8,
   parameter int LONG_TIMEOUT = 255,
   parameter int ABORT_CYCLES = 4
) (
   input  logic       LPC_CLK,
   input  logic       LPC_RST,
   lpc_host_if.master lpc
);
   localparam logic [8:0] SYNC_LIM   = 9'(SYNC_TIMEOUT);
   localparam logic [8:0] LONG_LIM   = 9'(LONG_TIMEOUT);
   localparam logic [7:0] ABORT_LAST = 8'(ABORT_CYCLES - 1);

   typedef enum logic [4:0] {
      S_IDLE, S_START, S_CYCTYPE, S_ADDR3, S_ADDR2, S_ADDR1, S_ADDR0,
      S_WDATA0, S_WDATA1, S_TAR_H, S_TAR_F, S_SYNC, S_RDATA0, S_RDATA1,
      S_TAR_T1, S_TAR_T2, S_DONE, S_ABORT, S_ABORT_END
   } state_t;

   state_t      state_q, state_d;
   logic        write_q, write_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        to_q, to_d;
   logic [8:0]  wait_cnt_q, wait_cnt_d;
   logic        wait_long_q, wait_long_d;
   logic [7:0]  abort_cnt_q, abort_cnt_d;
   logic        frame_q, frame_d;
   logic [3:0]  lad_out_q, lad_out_d;
   logic        lad_oe_q, lad_oe_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [7:0]  resp_rdata_q, resp_rdata_d;
   logic        resp_error_q, resp_error_d;
   logic        resp_timeout_q, resp_timeout_d;
   logic        sync_long;
   logic [8:0]  cnt_next;

   always_comb begin
      state_d        = state_q;
      write_d        = write_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      rdata_d        = rdata_q;
      err_d          = err_q;
      to_d           = to_q;
      wait_cnt_d     = wait_cnt_q;
      wait_long_d    = wait_long_q;
      abort_cnt_d    = abort_cnt_q;
      resp_rdata_d   = resp_rdata_q;
      resp_error_d   = resp_error_q;
      resp_timeout_d = resp_timeout_q;
      resp_valid_d   = 1'b0;
      sync_long      = (lpc.LPC_LAD_IN == 4'b0110);
      // A change between short and long wait restarts the run count.
      cnt_next       = (sync_long == wait_long_q) ? wait_cnt_q + 9'd1 : 9'd1;

      case (state_q)
         S_IDLE: begin
            if (lpc.req_valid) begin
               write_d = lpc.req_write;
               addr_d  = lpc.req_addr;
               wdata_d = lpc.req_wdata;
               err_d   = 1'b0;
               to_d    = 1'b0;
               state_d = S_START;
            end
         end
         S_START:   state_d = S_CYCTYPE;
         S_CYCTYPE: state_d = S_ADDR3;
         S_ADDR3:   state_d = S_ADDR2;
         S_ADDR2:   state_d = S_ADDR1;
         S_ADDR1:   state_d = S_ADDR0;
         S_ADDR0:   state_d = write_q ? S_WDATA0 : S_TAR_H;
         S_WDATA0:  state_d = S_WDATA1;
         S_WDATA1:  state_d = S_TAR_H;
         S_TAR_H:   state_d = S_TAR_F;
         S_TAR_F: begin
            wait_cnt_d  = 9'd0;
            wait_long_d = 1'b0;
            state_d     = S_SYNC;
         end
         S_SYNC: begin
            if (lpc.LPC_LAD_IN == 4'b0000 || lpc.LPC_LAD_IN == 4'b1010) begin
               err_d   = err_q | (lpc.LPC_LAD_IN == 4'b1010);
               state_d = write_q ? S_TAR_T1 : S_RDATA0;
            end else begin
               wait_cnt_d  = cnt_next;
               wait_long_d = sync_long;
               if (cnt_next >= (sync_long ? LONG_LIM : SYNC_LIM)) begin
                  to_d        = 1'b1;
                  abort_cnt_d = 8'd0;
                  state_d     = S_ABORT;
               end
            end
         end
         S_RDATA0: begin
            rdata_d[3:0] = lpc.LPC_LAD_IN;
            state_d      = S_RDATA1;
         end
         S_RDATA1: begin
            rdata_d[7:4] = lpc.LPC_LAD_IN;
            state_d      = S_TAR_T1;
         end
         S_TAR_T1:  state_d = S_TAR_T2;
         S_TAR_T2:  state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         S_ABORT: begin
            if (abort_cnt_q == ABORT_LAST) state_d = S_ABORT_END;
            else abort_cnt_d = abort_cnt_q + 8'd1;
         end
         S_ABORT_END: state_d = S_DONE;
         default:     state_d = S_IDLE;
      endcase

      // Pin values are derived from the next state so they change with it.
      frame_d     = !(state_d == S_START || state_d == S_ABORT);
      req_ready_d = (state_d == S_IDLE);
      lad_oe_d    = 1'b0;
      lad_out_d   = 4'hF;
      case (state_d)
         S_START:   begin lad_oe_d = 1'b1; lad_out_d = 4'h0;                          end
         S_CYCTYPE: begin lad_oe_d = 1'b1; lad_out_d = write_d ? 4'b0010 : 4'b0000;   end
         S_ADDR3:   begin lad_oe_d = 1'b1; lad_out_d = addr_d[15:12];                 end
         S_ADDR2:   begin lad_oe_d = 1'b1; lad_out_d = addr_d[11:8];                  end
         S_ADDR1:   begin lad_oe_d = 1'b1; lad_out_d = addr_d[7:4];                   end
         S_ADDR0:   begin lad_oe_d = 1'b1; lad_out_d = addr_d[3:0];                   end
         S_WDATA0:  begin lad_oe_d = 1'b1; lad_out_d = wdata_d[3:0];                  end
         S_WDATA1:  begin lad_oe_d = 1'b1; lad_out_d = wdata_d[7:4];                  end
         S_TAR_H:   begin lad_oe_d = 1'b1; lad_out_d = 4'hF;                          end
         S_ABORT:   begin lad_oe_d = 1'b1; lad_out_d = 4'hF;                          end
         default:   begin lad_oe_d = 1'b0; lad_out_d = 4'hF;                          end
      endcase

      if (state_d == S_DONE) begin
         resp_valid_d   = 1'b1;
         resp_error_d   = err_d | to_d;
         resp_timeout_d = to_d;
         if (!write_d && !to_d) resp_rdata_d = rdata_d;
      end
   end

   always_ff @(posedge LPC_CLK or negedge LPC_RST) begin
      if (!LPC_RST) begin
         state_q        <= S_IDLE;
         write_q        <= 1'b0;
         addr_q         <= 16'h0000;
         wdata_q        <= 8'h00;
         rdata_q        <= 8'h00;
         err_q          <= 1'b0;
         to_q           <= 1'b0;
         wait_cnt_q     <= 9'd0;
         wait_long_q    <= 1'b0;
         abort_cnt_q    <= 8'd0;
         frame_q        <= 1'b1;
         lad_out_q      <= 4'hF;
         lad_oe_q       <= 1'b0;
         req_ready_q    <= 1'b1;
         resp_valid_q   <= 1'b0;
         resp_rdata_q   <= 8'h00;
         resp_error_q   <= 1'b0;
         resp_timeout_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         write_q        <= write_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         rdata_q        <= rdata_d;
         err_q          <= err_d;
         to_q           <= to_d;
         wait_cnt_q     <= wait_cnt_d;
         wait_long_q    <= wait_long_d;
         abort_cnt_q    <= abort_cnt_d;
         frame_q        <= frame_d;
         lad_out_q      <= lad_out_d;
         lad_oe_q       <= lad_oe_d;
         req_ready_q    <= req_ready_d;
         resp_valid_q   <= resp_valid_d;
         resp_rdata_q   <= resp_rdata_d;
         resp_error_q   <= resp_error_d;
         resp_timeout_q <= resp_timeout_d;
      end
   end

   assign lpc.req_ready    = req_ready_q;
   assign lpc.resp_valid   = resp_valid_q;
   assign lpc.resp_rdata   = resp_rdata_q;
   assign lpc.resp_error   = resp_error_q;
   assign lpc.resp_timeout = resp_timeout_q;
   assign lpc.LPC_FRAME    = frame_q;
   assign lpc.LPC_LAD_OUT  = lad_out_q;
   assign lpc.LPC_LAD_OE   = lad_oe_q;
endmodule

// File: tb/tb_lpc_host.sv
// Bench for lpc_host: table of directed cycles, random cycles against a
// per-cycle bus trace model, plus reset-mid-cycle and back-to-back sequences.
module tb_lpc_host;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lpc_host_if lpc ();

   lpc_host #(.SYNC_TIMEOUT(8), .LONG_TIMEOUT(255), .ABORT_CYCLES(4)) dut (
      .LPC_CLK (clk),
      .LPC_RST (rst_n),
      .lpc     (lpc.master)
   );

   typedef struct {
      logic       frame;
      logic       oe;
      logic [3:0] lad;
      logic [3:0] lin;
   } cyc_t;

   typedef struct {
      logic        w;
      logic [15:0] a;
      logic [7:0]  d;
      int          n1; logic [3:0] v1;
      int          n2; logic [3:0] v2;
      int          n3; logic [3:0] v3;
      logic        fin_en; logic [3:0] fin;
      int          lat;
      logic        err;
      logic        to;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   int         txn_no = 0;
   cyc_t       exp_q[$];
   logic [3:0] script_q[$];
   logic       m_err, m_to;
   logic [7:0] exp_rdata = 8'h00;
   vec_t       vt[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (txn %0d)", name, act, req, txn_no);
      end
   endtask

   task automatic push(input logic f, input logic oe, input logic [3:0] lad, input logic [3:0] lin);
      cyc_t c;
      c.frame = f; c.oe = oe; c.lad = lad; c.lin = lin;
      exp_q.push_back(c);
   endtask

   // Expected pin trace, one entry per bus cycle after the accept edge,
   // together with the LAD value the target presents in that cycle.
   task automatic model(input logic w, input logic [15:0] a, input logic [7:0] d);
      int run, prev, cat;
      bit stop;
      exp_q.delete();
      m_err = 1'b0;
      m_to  = 1'b0;
      push(1'b0, 1'b1, 4'h0, 4'hF);
      push(1'b1, 1'b1, w ? 4'h2 : 4'h0, 4'hF);
      for (int i = 3; i >= 0; i--) push(1'b1, 1'b1, a[i*4 +: 4], 4'hF);
      if (w) begin
         push(1'b1, 1'b1, d[3:0], 4'hF);
         push(1'b1, 1'b1, d[7:4], 4'hF);
      end
      push(1'b1, 1'b1, 4'hF, 4'hF);
      push(1'b1, 1'b0, 4'hF, 4'hF);
      run = 0; prev = -1; stop = 1'b0;
      for (int i = 0; i < script_q.size() && !stop; i++) begin
         push(1'b1, 1'b0, 4'hF, script_q[i]);
         if (script_q[i] == 4'h0) stop = 1'b1;
         else if (script_q[i] == 4'hA) begin m_err = 1'b1; stop = 1'b1; end
         else begin
            cat  = (script_q[i] == 4'h6) ? 1 : 0;
            run  = (cat == prev) ? run + 1 : 1;
            prev = cat;
            if (run >= (cat == 1 ? 255 : 8)) begin m_to = 1'b1; stop = 1'b1; end
         end
      end
      if (m_to) begin
         m_err = 1'b1;
         repeat (4) push(1'b0, 1'b1, 4'hF, 4'hF);
         push(1'b1, 1'b0, 4'hF, 4'hF);
      end else begin
         if (!w) begin
            push(1'b1, 1'b0, 4'hF, d[3:0]);
            push(1'b1, 1'b0, 4'hF, d[7:4]);
         end
         push(1'b1, 1'b0, 4'hF, 4'hF);
         push(1'b1, 1'b0, 4'hF, 4'hF);
      end
      push(1'b1, 1'b0, 4'hF, 4'hF);
   endtask

   // Caller is positioned at a negedge; returns at the negedge of the IDLE cycle.
   task automatic run_txn(input logic w, input logic [15:0] a, input logic [7:0] d,
                          input int lat, input logic eerr, input logic eto, input bit hold);
      int n;
      n = 0;
      txn_no++;
      while (lpc.req_ready !== 1'b1 && n < 400) begin @(negedge clk); n++; end
      chk("ready_before_req", 32'(lpc.req_ready), 32'd1);
      lpc.req_write = w;
      lpc.req_addr  = a;
      lpc.req_wdata = w ? d : 8'($urandom);
      lpc.req_valid = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) lpc.req_valid = 1'b0;
      lpc.req_addr  = 16'($urandom);
      lpc.req_wdata = 8'($urandom);
      if (!w && !eto) exp_rdata = d;
      for (int c = 0; c < exp_q.size(); c++) begin
         lpc.LPC_LAD_IN = exp_q[c].lin;
         @(negedge clk);
         chk($sformatf("bus_cycle%0d", c + 1),
             {lpc.LPC_FRAME, lpc.LPC_LAD_OE, lpc.LPC_LAD_OE ? lpc.LPC_LAD_OUT : 4'h0,
              lpc.resp_valid, lpc.req_ready},
             {exp_q[c].frame, exp_q[c].oe, exp_q[c].oe ? exp_q[c].lad : 4'h0,
              (c + 1 == lat), 1'b0});
         if (c + 1 == lat) begin
            chk("resp_error", 32'(lpc.resp_error), 32'(eerr));
            chk("resp_timeout", 32'(lpc.resp_timeout), 32'(eto));
            chk("resp_rdata", 32'(lpc.resp_rdata), 32'(exp_rdata));
         end
         @(posedge clk);
         #1;
      end
      lpc.LPC_LAD_IN = 4'hF;
      @(negedge clk);
      chk("idle_after", {lpc.req_ready, lpc.LPC_FRAME, lpc.LPC_LAD_OE, lpc.resp_valid}, 4'b1100);
      $display("txn %0d %s addr=%04h data=%02h cycles=%0d rdata=%02h err=%0b to=%0b",
               txn_no, w ? "WR" : "RD", a, d, exp_q.size(), lpc.resp_rdata,
               lpc.resp_error, lpc.resp_timeout);
   endtask

   task automatic build_script(input vec_t v);
      script_q.delete();
      repeat (v.n1) script_q.push_back(v.v1);
      repeat (v.n2) script_q.push_back(v.v2);
      repeat (v.n3) script_q.push_back(v.v3);
      if (v.fin_en) script_q.push_back(v.fin);
   endtask

   initial begin
      lpc.req_valid  = 1'b0;
      lpc.req_write  = 1'b0;
      lpc.req_addr   = 16'h0000;
      lpc.req_wdata  = 8'h00;
      lpc.LPC_LAD_IN = 4'hF;

      //           w     addr      data   n1  v1    n2 v2    n3 v3    fin   fin    lat  err   to
      vt[0] = '{1'b1, 16'h03F8, 8'h41,   0, 4'h5, 0, 4'h0, 0, 4'h0, 1'b1, 4'h0,  14, 1'b0, 1'b0};
      vt[1] = '{1'b0, 16'h03FD, 8'h60,   2, 4'h5, 0, 4'h0, 0, 4'h0, 1'b1, 4'h0,  16, 1'b0, 1'b0};
      vt[2] = '{1'b0, 16'h0080, 8'hFF,   0, 4'h5, 0, 4'h0, 0, 4'h0, 1'b1, 4'hA,  14, 1'b1, 1'b0};
      vt[3] = '{1'b1, 16'h0070, 8'h55,  20, 4'hF, 0, 4'h0, 0, 4'h0, 1'b0, 4'h0,  24, 1'b1, 1'b1};
      vt[4] = '{1'b0, 16'h0060, 8'h3C, 100, 4'h6, 0, 4'h0, 0, 4'h0, 1'b1, 4'h0, 114, 1'b0, 1'b0};
      vt[5] = '{1'b1, 16'h002E, 8'hA7, 254, 4'h6, 0, 4'h0, 0, 4'h0, 1'b1, 4'h0, 268, 1'b0, 1'b0};
      vt[6] = '{1'b0, 16'h0C10, 8'h9E, 255, 4'h6, 0, 4'h0, 0, 4'h0, 1'b0, 4'h0, 269, 1'b1, 1'b1};
      vt[7] = '{1'b0, 16'hBEEF, 8'h5A,   7, 4'h5, 0, 4'h0, 0, 4'h0, 1'b1, 4'h0,  21, 1'b0, 1'b0};
      vt[8] = '{1'b0, 16'h4321, 8'hC3,   7, 4'h5, 1, 4'h6, 7, 4'h5, 1'b1, 4'h0,  29, 1'b0, 1'b0};
      vt[9] = '{1'b1, 16'h8001, 8'h18,   8, 4'h5, 0, 4'h0, 0, 4'h0, 1'b0, 4'h0,  24, 1'b1, 1'b1};

      @(negedge clk);
      chk("reset_pins", {lpc.LPC_FRAME, lpc.LPC_LAD_OE, lpc.LPC_LAD_OUT}, 6'b10_1111);
      chk("reset_resp", {lpc.resp_valid, lpc.resp_rdata, lpc.resp_error, lpc.resp_timeout}, 11'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 32'(lpc.req_ready), 32'd1);

      foreach (vt[i]) begin
         build_script(vt[i]);
         model(vt[i].w, vt[i].a, vt[i].d);
         run_txn(vt[i].w, vt[i].a, vt[i].d, vt[i].lat, vt[i].err, vt[i].to, 1'b0);
      end

      for (int r = 0; r < 20; r++) begin
         logic        w;
         logic [15:0] a;
         logic [7:0]  d;
         logic [3:0]  pick[4];
         pick[0] = 4'h5; pick[1] = 4'hF; pick[2] = 4'h6; pick[3] = 4'h3;
         w = 1'($urandom_range(0, 1));
         a = 16'($urandom);
         d = 8'($urandom);
         script_q.delete();
         repeat ($urandom_range(0, 3)) begin
            logic [3:0] v;
            v = pick[$urandom_range(0, 3)];
            repeat ($urandom_range(1, 9)) script_q.push_back(v);
         end
         script_q.push_back(($urandom_range(0, 3) == 0) ? 4'hA : 4'h0);
         model(w, a, d);
         run_txn(w, a, d, exp_q.size(), m_err, m_to, 1'b0);
      end

      // Reset asserted mid-cycle during ADDR1 of a write.
      txn_no++;
      lpc.req_write = 1'b1; lpc.req_addr = 16'h1234; lpc.req_wdata = 8'h77;
      lpc.req_valid = 1'b1;
      @(posedge clk);
      #1;
      lpc.req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("addr1_nibble", {lpc.LPC_LAD_OE, lpc.LPC_LAD_OUT}, {1'b1, 4'h3});
      rst_n = 1'b0;
      #1;
      chk("async_reset_pins", {lpc.LPC_FRAME, lpc.LPC_LAD_OE, lpc.LPC_LAD_OUT, lpc.req_ready},
          7'b1_0_1111_1);
      exp_rdata = 8'h00;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 3) rst_n = 1'b1;
         chk($sformatf("no_resp_after_reset%0d", k), {lpc.resp_valid, lpc.LPC_FRAME, lpc.LPC_LAD_OE},
             3'b010);
      end
      $display("txn %0d reset during ADDR1 of write to 1234", txn_no);
      script_q.delete();
      script_q.push_back(4'h0);
      model(1'b0, 16'h02F8, 8'hD2);
      run_txn(1'b0, 16'h02F8, 8'hD2, exp_q.size(), 1'b0, 1'b0, 1'b0);

      // req_valid held high across two requests.
      script_q.delete();
      script_q.push_back(4'h0);
      model(1'b1, 16'h03F9, 8'h0B);
      run_txn(1'b1, 16'h03F9, 8'h0B, 14, 1'b0, 1'b0, 1'b1);
      model(1'b0, 16'h03FA, 8'hE4);
      run_txn(1'b0, 16'h03FA, 8'hE4, 14, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lpc_host.md
Name: lpc_host

Overview:
- LPC bus initiator that issues single-byte LPC I/O read and I/O write cycles on behalf of a simple request/response interface.
- Drives LFRAME# and LAD[3:0], turns the bus around, and samples the target's SYNC and read data.
- Handles short and long waits, error SYNC, and no-response timeout with an LPC abort.
- Used as the bench-side and test-fixture counterpart of the team's LPC peripheral devices (e.g. the LPC UART).

Parameters:
- SYNC_TIMEOUT, 8: maximum consecutive SYNC cycles showing short wait (0101) or any non-SYNC value before abort.
- LONG_TIMEOUT, 255: maximum consecutive SYNC cycles showing long wait (0110) before abort.
- ABORT_CYCLES, 4: LFRAME# low cycles during abort; must be at least 4.

Ports:
- LPC_CLK  in  1  LPC clock; all logic on rising edge.
- LPC_RST  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready.
- req_write  in  1  1 = I/O write, 0 = I/O read.
- req_addr  in  16  I/O address.
- req_wdata  in  8  write data.
- resp_valid  out  1  one-cycle pulse at cycle completion.
- resp_rdata  out  8  read data; held until next resp_valid.
- resp_error  out  1  error SYNC or timeout; qualified by resp_valid.
- resp_timeout  out  1  timeout/abort occurred; qualified by resp_valid.
- LPC_FRAME  out  1  LFRAME#, active-low.
- LPC_LAD_OUT  out  4  LAD drive value.
- LPC_LAD_OE  out  1  LAD output enable.
- LPC_LAD_IN  in  4  sampled LAD.

Behaviour:
- Reset (LPC_RST=0, any time, mid-cycle included), asynchronous:
  - State goes to IDLE.
  - LPC_FRAME=1, LPC_LAD_OE=0, LPC_LAD_OUT=4'hF.
  - resp_valid=0, resp_rdata=0, resp_error=0, resp_timeout=0; req_ready=1 after reset.
  - No response is produced for the interrupted cycle.
- Acceptance: on the accept edge, latch write, addr and wdata. req_* is ignored outside IDLE.
- Registered state sequence, one state per LPC_CLK cycle:
  - START: FRAME=0, OE=1, LAD=0000.
  - CYCTYPE: FRAME=1, LAD=0010 for write, 0000 for read.
  - ADDR3..ADDR0: addr[15:12] first, down to addr[3:0].
  - Write only, WDATA0, WDATA1: wdata[3:0], then wdata[7:4].
  - TAR_H: OE=1, LAD=1111.
  - TAR_F: OE=0.
  - SYNC: OE=0; sample LAD_IN each cycle:
    - 0000 -> ready; next is RDATA0 for a read, TAR_T1 for a write.
    - 1010 -> set error flag; otherwise treated as ready.
    - 0110 -> long wait; increment wait counter, limit LONG_TIMEOUT.
    - Any other value (incl. 0101, 1111) -> increment wait counter, limit SYNC_TIMEOUT.
    - Wait counter clears on entry to SYNC and when the wait type changes.
    - Counter reaching its limit -> ABORT.
  - Read only, RDATA0, RDATA1: capture rdata[3:0], then rdata[7:4].
  - TAR_T1, TAR_T2: OE=0; target owns the bus.
  - DONE: resp_valid=1, resp_rdata updated (reads only), resp_error, resp_timeout=0; next IDLE.
  - ABORT: FRAME=0, OE=1, LAD=1111 for ABORT_CYCLES cycles. Then FRAME=1 and OE=0 for one cycle, then DONE with resp_error=1, resp_timeout=1, resp_rdata unchanged.
- Latency with zero wait (SYNC=0000 on the first SYNC cycle):
  - Both directions occupy 13 bus cycles after the accept edge.
  - resp_valid is high in the 14th cycle.
  - req_ready returns in the 15th cycle.
  - Each wait cycle adds 1.
- LAD is never driven by the host from TAR_F through TAR_T2.
- Back-to-back requests: at least one IDLE cycle between cycles (bus idles with FRAME=1, OE=0).

Test Plan:
- Write addr 16'h03F8, data 8'h41, target SYNC=0000 immediately:
  - LAD sequence 0000,0010,0,3,F,8,1,4,1111, then float.
  - resp_valid in cycle 14 with resp_error=0.
- Read addr 16'h03FD, target SYNC 0101,0101,0000, data nibbles 0,6:
  - resp_rdata=8'h60 and resp_valid in cycle 16, resp_error=0.
- Read with SYNC=1010, data 8'hFF -> resp_error=1, resp_timeout=0, resp_rdata=8'hFF.
- Write with no target (LAD_IN=1111 throughout):
  - After 8 SYNC cycles, FRAME low 4 cycles with LAD=1111.
  - Then resp_valid with resp_error=1, resp_timeout=1.
- Long wait 0110 for 100 cycles, then 0000 -> no abort; completes normally.
- Assert LPC_RST low during ADDR1 of a write:
  - FRAME=1 and OE=0 immediately, without waiting for a clock edge.
  - No resp_valid.
  - After reset release, a new read completes normally.
- req_valid held high throughout -> second request is accepted only after the first resp_valid, with one IDLE cycle between bus cycles.
